// File: rtl/riscv_pkg.sv
// Shared RV32I constants: data width, register count, register address type,
// ABI register indices and the default stack-pointer reset value.
package riscv_pkg;

  localparam int unsigned RV_XLEN  = 32;
  localparam int unsigned RV_NREGS = 32;

  typedef logic [4:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
  localparam reg_addr_t REG_SP   = 5'd2;

  localparam logic [31:0] SP_INIT_DEFAULT = 32'h0000_03FC;

endpackage

// File: rtl/register_unit.sv
// Integer register file: x1..x31 storage, two combinational read ports,
// one synchronous write port and a registered debug read port.
// Optional build macro: REGFILE_SP_INIT_EN (x2 resets to SP_INIT).
module register_unit
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN    = RV_XLEN,
  parameter int unsigned     NREGS   = RV_NREGS,
  parameter logic [XLEN-1:0] SP_INIT = SP_INIT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  reg_addr_t       rs1,
  input  reg_addr_t       rs2,
  input  reg_addr_t       rd,
  input  logic [XLEN-1:0] DataWr,
  input  logic            RUWr,
  output logic [XLEN-1:0] RUrs1,
  output logic [XLEN-1:0] RUrs2,
  input  reg_addr_t       DbgAddr,
  input  logic            DbgRd,
  output logic [XLEN-1:0] DbgData,
  output logic            DbgValid
);

  // x0 is not stored; index 0 is decoded to zero on every read path
  logic [XLEN-1:0] regs_q [1:NREGS-1];
  logic [XLEN-1:0] regs_d [1:NREGS-1];
  logic [XLEN-1:0] dbg_data_q, dbg_data_d;
  logic            dbg_valid_q, dbg_valid_d;

`ifndef REGFILE_SP_INIT_EN
  logic unused_sp_init;
  assign unused_sp_init = ^SP_INIT;
`endif

  // Combinational operand reads; no write bypass so ALU -> DataWr stays acyclic
  always_comb begin
    RUrs1 = (rs1 == REG_ZERO) ? '0 : regs_q[rs1];
    RUrs2 = (rs2 == REG_ZERO) ? '0 : regs_q[rs2];
  end

  // Next-state: write port (x0 writes dropped) and debug capture of pre-edge state
  always_comb begin
    regs_d      = regs_q;
    dbg_data_d  = dbg_data_q;
    dbg_valid_d = DbgRd;
    if (RUWr && (rd != REG_ZERO)) begin
      regs_d[rd] = DataWr;
    end
    if (DbgRd) begin
      dbg_data_d = (DbgAddr == REG_ZERO) ? '0 : regs_q[DbgAddr];
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 1; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
`ifdef REGFILE_SP_INIT_EN
      regs_q[REG_SP] <= SP_INIT;
`endif
      dbg_data_q  <= '0;
      dbg_valid_q <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      dbg_data_q  <= dbg_data_d;
      dbg_valid_q <= dbg_valid_d;
    end
  end

  // Debug outputs
  always_comb begin
    DbgData  = dbg_data_q;
    DbgValid = dbg_valid_q;
  end

endmodule

// File: tb/tb_register_unit.sv
// Self-checking bench for register_unit: reset sweep, vector table,
// directed corner sequences and a randomized phase against an array model.
module tb_register_unit;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1, rs2, rd, DbgAddr;
  logic [31:0] DataWr;
  logic        RUWr, DbgRd;
  logic [31:0] RUrs1, RUrs2, DbgData;
  logic        DbgValid;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural registers plus debug output state
  logic [31:0] m [32];
  logic [31:0] m_dbg;
  logic        m_valid;

  register_unit #(.XLEN(32), .NREGS(32), .SP_INIT(32'h0000_03FC)) dut (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rd(rd), .DataWr(DataWr),
    .RUWr(RUWr), .RUrs1(RUrs1), .RUrs2(RUrs2), .DbgAddr(DbgAddr),
    .DbgRd(DbgRd), .DbgData(DbgData), .DbgValid(DbgValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
    logic [4:0]  dbg_addr;
    logic        dbg_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] exp_rs1;
    logic [31:0] exp_rs2;
    logic        exp_valid;
    logic [31:0] exp_dbg;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m[i] = 32'h0;
`ifdef REGFILE_SP_INIT_EN
    m[2] = 32'h0000_03FC;
`endif
    m_dbg   = 32'h0;
    m_valid = 1'b0;
  endtask

  // Drive one cycle of inputs, clock it, advance the model, settle 1 time unit
  task automatic cycle(input logic [4:0] a_rd, input logic [31:0] a_data, input logic a_we,
                       input logic [4:0] a_dbga, input logic a_dbgrd,
                       input logic [4:0] a_rs1, input logic [4:0] a_rs2);
    rd = a_rd; DataWr = a_data; RUWr = a_we;
    DbgAddr = a_dbga; DbgRd = a_dbgrd; rs1 = a_rs1; rs2 = a_rs2;
    @(posedge clk);
    if (a_dbgrd) begin
      m_dbg   = m[a_dbga];
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    if (a_we && a_rd != 5'd0) m[a_rd] = a_data;
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_rs1"}, RUrs1, m[rs1]);
    check({tag, "_rs2"}, RUrs2, m[rs2]);
    check({tag, "_valid"}, {31'b0, DbgValid}, {31'b0, m_valid});
    check({tag, "_dbg"}, DbgData, m_dbg);
  endtask

  initial begin
    logic [31:0] sp_exp;
`ifdef REGFILE_SP_INIT_EN
    sp_exp = 32'h0000_03FC;
`else
    sp_exp = 32'h0;
`endif
    rst = 1'b1; rs1 = '0; rs2 = '0; rd = '0; DataWr = '0; RUWr = 1'b0;
    DbgAddr = '0; DbgRd = 1'b0;
    model_reset();
    #22;

    // Reset sweep while rst is held
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(31 - i);
      #1;
      check("rst_rs1", RUrs1, (i == 2) ? sp_exp : 32'h0);
      check("rst_rs2", RUrs2, (31 - i == 2) ? sp_exp : 32'h0);
    end
    check("rst_valid", {31'b0, DbgValid}, 32'h0);
    check("rst_dbg", DbgData, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    //            rd     data          we    dbga   dbgrd rs1    rs2    exp_rs1       exp_rs2       vld   exp_dbg
    vecs[0] = '{5'd5,  32'hDEADBEEF, 1'b1, 5'd0,  1'b0, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1] = '{5'd0,  32'hFFFFFFFF, 1'b1, 5'd5,  1'b1, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 1'b1, 32'hDEADBEEF};
    vecs[2] = '{5'd7,  32'h12345678, 1'b0, 5'd0,  1'b0, 5'd7,  5'd0,  32'h0,        32'h0,        1'b0, 32'hDEADBEEF};
    vecs[3] = '{5'd7,  32'h11110000, 1'b1, 5'd7,  1'b1, 5'd7,  5'd5,  32'h11110000, 32'hDEADBEEF, 1'b1, 32'h0};
    vecs[4] = '{5'd31, 32'h80000001, 1'b1, 5'd7,  1'b1, 5'd31, 5'd7,  32'h80000001, 32'h11110000, 1'b1, 32'h11110000};
    vecs[5] = '{5'd0,  32'h0,        1'b0, 5'd31, 1'b1, 5'd31, 5'd31, 32'h80000001, 32'h80000001, 1'b1, 32'h80000001};
    vecs[6] = '{5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 32'h80000001};
    vecs[7] = '{5'd0,  32'h0,        1'b0, 5'd0,  1'b1, 5'd7,  5'd31, 32'h11110000, 32'h80000001, 1'b1, 32'h0};

    foreach (vecs[i]) begin
      cycle(vecs[i].rd, vecs[i].data, vecs[i].we, vecs[i].dbg_addr, vecs[i].dbg_rd,
            vecs[i].rs1, vecs[i].rs2);
      check($sformatf("vec%0d_rs1", i), RUrs1, vecs[i].exp_rs1);
      check($sformatf("vec%0d_rs2", i), RUrs2, vecs[i].exp_rs2);
      check($sformatf("vec%0d_valid", i), {31'b0, DbgValid}, {31'b0, vecs[i].exp_valid});
      check($sformatf("vec%0d_dbg", i), DbgData, vecs[i].exp_dbg);
    end

    // Debug read colliding with a write to the same register
    cycle(5'd9, 32'h01020304, 1'b1, 5'd0, 1'b0, 5'd9, 5'd0);
    check("coll_pre_x9", RUrs1, 32'h01020304);
    cycle(5'd9, 32'hA5A5A5A5, 1'b1, 5'd9, 1'b1, 5'd9, 5'd0);
    check("coll_dbg_old", DbgData, 32'h01020304);
    check("coll_valid", {31'b0, DbgValid}, 32'h1);
    check("coll_rs1_new", RUrs1, 32'hA5A5A5A5);
    cycle(5'd0, 32'h0, 1'b0, 5'd9, 1'b1, 5'd9, 5'd0);
    check("coll_dbg_new", DbgData, 32'hA5A5A5A5);
    check("coll_valid2", {31'b0, DbgValid}, 32'h1);
    cycle(5'd0, 32'h0, 1'b0, 5'd9, 1'b0, 5'd9, 5'd0);
    check("coll_valid_drop", {31'b0, DbgValid}, 32'h0);
    check("coll_dbg_hold", DbgData, 32'hA5A5A5A5);

    // Asynchronous reset between edges with a write pending
    cycle(5'd3, 32'h00000008, 1'b1, 5'd0, 1'b0, 5'd3, 5'd0);
    check("arst_pre_x3", RUrs1, 32'h00000008);
    rd = 5'd3; DataWr = 32'hFFFF0000; RUWr = 1'b1; DbgRd = 1'b1; DbgAddr = 5'd3;
    #2;
    rst = 1'b1;
    #1;
    check("arst_x3_cleared", RUrs1, 32'h0);
    check("arst_valid", {31'b0, DbgValid}, 32'h0);
    check("arst_dbg", DbgData, 32'h0);
    @(posedge clk);
    #1;
    check("arst_write_lost", RUrs1, 32'h0);
    check("arst_valid_held", {31'b0, DbgValid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cycle(5'd3, 32'h00000055, 1'b1, 5'd0, 1'b0, 5'd3, 5'd2);
    check("arst_first_write", RUrs1, 32'h00000055);
    check("arst_sp", RUrs2, sp_exp);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      cycle(5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      check_model("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
